free_list: RTL
==============

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameters are the shared macros, not module parameters: `N_WAY` (2) = dispatch/retire width; `N_ROB` (8) = ROB entries; `N_PHYS_REG` (64) = physical tags; `N_ARCH_REG` (32) = architectural registers; `CDB_BITS` = $clog2(`N_PHYS_REG`).
REQ-002 Ports:
- clock, input, 1: the single clock.
- reset, input, 1: asynchronous, active-low reset.
REQ-003 retire_valid, input, `N_WAY`: retire lane k is valid.
REQ-004 retire_told, input, `N_WAY`x`CDB_BITS`: old tag freed at retire of lane k.
REQ-005 branch_haz, input, 1: mispredict recovery in this cycle.
REQ-006 free_list_haz, input, `N_ROB`x`CDB_BITS`: squashed tags to reclaim; 0 means no tag.
REQ-007 alloc_req, input, `N_WAY`: dispatch lane k requests a tag; lanes are contiguous from lane 0.
REQ-008 alloc_tag, output, `N_WAY`x`CDB_BITS`: tag offered to lane k.
REQ-009 alloc_valid, output, `N_WAY`: alloc_tag[k] is valid.
REQ-010 free_avail, output, $clog2(`N_WAY`)+1: min(free_count, `N_WAY`).
REQ-011 free_count, output, $clog2(`N_PHYS_REG`)+1: tags currently held.
REQ-012 overflow, output, 1: sticky error flag.

Function
REQ-013 Storage is a circular FIFO of FL_DEPTH = `N_PHYS_REG`-`N_ARCH_REG` (32) entries, with head pointer, tail pointer and count registers; pointers wrap modulo FL_DEPTH.
REQ-014 Allocation is zero-latency from registered state:
- alloc_tag[k] = mem[(head+k) mod FL_DEPTH].
- alloc_valid[k] = (count > k) and not branch_haz.
REQ-015 Pops per cycle = popcount(alloc_req & alloc_valid); head advances by that number at the clock edge.
REQ-016 A request with alloc_valid low is not granted and consumes nothing; a non-contiguous alloc_req is illegal and its behaviour is unspecified.
REQ-017 Push candidates per cycle, in fixed priority order:
- retire lanes 0..`N_WAY`-1 where retire_valid[k] is high and retire_told[k] is nonzero;
- then, only when branch_haz is high, free_list_haz[0..`N_ROB`-1] entries that are nonzero.
REQ-018 Candidates are compacted and written at consecutive positions starting at tail, with wrap; tail advances by the push count.
REQ-019 Tag 0 is never pushed and never allocated.
REQ-020 Next count = count + pushes - pops, all in one cycle.
REQ-021 Tags pushed in cycle N are allocatable no earlier than cycle N+1; there is no push-to-alloc bypass.
REQ-022 branch_haz forces zero pops in that cycle; retire pushes in the same cycle still occur.
REQ-023 If count + pushes - pops > FL_DEPTH:
- the excess pushes are dropped;
- count saturates at FL_DEPTH;
- overflow sets and holds until reset.
REQ-024 Empty (count = 0): all alloc_valid low, free_avail = 0, pops = 0, and pushes proceed normally.

Reset
REQ-025 While reset is low, asynchronously:
- mem[i] = `N_ARCH_REG`+i;
- head = 0, tail = 0 (full wrap);
- count = FL_DEPTH;
- overflow = 0.
REQ-026 Output values during and immediately after reset:
- alloc_tag = {32,33};
- alloc_valid = 2'b11;
- free_avail = 2;
- free_count = 32.
REQ-027 Asserting reset mid-operation discards all pending pushes and pops and takes effect without a clock edge.

Structure
REQ-028 `N_PHYS_REG`, `N_ARCH_REG` and FL_DEPTH are defined in the shared sys_defs header alongside `N_WAY`, `N_ROB` and `CDB_BITS`.
REQ-029 Push compaction (prefix count plus indexed write of up to `N_WAY`+`N_ROB` candidates) is a sub-module named fl_push_compact; the pointer, count and flag registers stay in free_list.

Verification
REQ-030 Reset released, alloc_req=2'b11 for 1 cycle -> grants 32,33; next cycle offers 34,35; free_count=30.
REQ-031 alloc_req=2'b11 for 16 cycles -> free_count=0, alloc_valid=2'b00, free_avail=0; a further request leaves count at 0.
REQ-032 From empty, retire_valid=2'b11 with told {5,0} -> exactly one push; next cycle alloc_tag[0]=5, alloc_valid=2'b01, free_count=1.
REQ-033 branch_haz=1 with free_list_haz={40,41,0,0,0,0,0,42}, retire_told[0]=7 valid, alloc_req=2'b11 -> no grants; FIFO order 7,40,41,42; count +4.
REQ-034 Push that exceeds FL_DEPTH from count=31 (two retire pushes) -> count=32; overflow=1 and stays 1.
REQ-035 reset driven low between clock edges mid-stream -> outputs equal the REQ-026 values before the next edge.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared sys_defs machine-width macros plus derived free-list constants and pointer helper.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define N_WAY      2
`define N_ROB      8
`define N_PHYS_REG 64
`define N_ARCH_REG 32
`define CDB_BITS   $clog2(`N_PHYS_REG)
`define FL_DEPTH   (`N_PHYS_REG - `N_ARCH_REG)
`endif

package free_list_pkg;
  localparam int NW       = `N_WAY;
  localparam int NROB     = `N_ROB;
  localparam int NPHYS    = `N_PHYS_REG;
  localparam int NARCH    = `N_ARCH_REG;
  localparam int CB       = `CDB_BITS;
  localparam int FL_DEPTH = `FL_DEPTH;
  localparam int PTR_W    = $clog2(FL_DEPTH);
  localparam int CNT_W    = $clog2(NPHYS) + 1;
  localparam int AVAIL_W  = $clog2(NW) + 1;
  localparam int NCAND    = NW + NROB;
  localparam int PCNT_W   = $clog2(NCAND + 1);

  // FIFO pointer plus offset, wrapped modulo FL_DEPTH.
  function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] p, input int unsigned off);
    int unsigned s;
    s = (32'(p) + off) % FL_DEPTH;
    return s[PTR_W-1:0];
  endfunction
endpackage

// File: rtl/fl_push_compact.sv
// Packs valid push candidates (priority order) into consecutive slots and counts them.
module fl_push_compact
  import free_list_pkg::*;
(
  input  logic [NCAND-1:0]         i_vld,
  input  logic [NCAND-1:0][CB-1:0] i_tag,
  output logic [NCAND-1:0][CB-1:0] o_tag,
  output logic [PCNT_W-1:0]        o_cnt
);
  logic [PCNT_W-1:0] w_pos;

  always_comb begin
    o_tag = '0;
    w_pos = '0;
    for (int i = 0; i < NCAND; i++) begin
      if (i_vld[i]) begin
        o_tag[w_pos] = i_tag[i];
        w_pos        = w_pos + PCNT_W'(1);
      end
    end
    o_cnt = w_pos;
  end
endmodule

// File: rtl/free_list.sv
// Physical-tag free list: circular FIFO, zero-latency multi-lane allocate, compacted multi-push.
module free_list
  import free_list_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NW-1:0]          retire_valid,
  input  logic [NW-1:0][CB-1:0]  retire_told,
  input  logic                   branch_haz,
  input  logic [NROB-1:0][CB-1:0] free_list_haz,
  input  logic [NW-1:0]          alloc_req,
  output logic [NW-1:0][CB-1:0]  alloc_tag,
  output logic [NW-1:0]          alloc_valid,
  output logic [AVAIL_W-1:0]     free_avail,
  output logic [CNT_W-1:0]       free_count,
  output logic                   overflow
);
  logic [CB-1:0]    r_mem [FL_DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic [NCAND-1:0]         w_cvld;
  logic [NCAND-1:0][CB-1:0] w_ctag, w_comp;
  logic [PCNT_W-1:0]        w_push;
  logic [CNT_W-1:0]         w_pops, w_live, w_room, w_acc;
  logic                     w_ovf;

  for (genvar k = 0; k < NW; k++) begin : g_lane
    assign alloc_tag[k]   = r_mem[wrap(r_head, k)];
    assign alloc_valid[k] = (r_count > CNT_W'(k)) && !branch_haz;
  end

  always_comb begin
    for (int k = 0; k < NW; k++) begin
      w_cvld[k] = retire_valid[k] && (retire_told[k] != '0);
      w_ctag[k] = retire_told[k];
    end
    // Squashed tags only count as candidates during recovery.
    for (int i = 0; i < NROB; i++) begin
      w_cvld[NW+i] = branch_haz && (free_list_haz[i] != '0);
      w_ctag[NW+i] = free_list_haz[i];
    end
  end

  fl_push_compact u_compact (
    .i_vld (w_cvld),
    .i_tag (w_ctag),
    .o_tag (w_comp),
    .o_cnt (w_push)
  );

  always_comb begin
    w_pops = '0;
    for (int k = 0; k < NW; k++)
      if (alloc_req[k] && alloc_valid[k]) w_pops = w_pops + CNT_W'(1);
    w_live = r_count - w_pops;
    w_room = CNT_W'(FL_DEPTH) - w_live;
    w_ovf  = CNT_W'(w_push) > w_room;
    w_acc  = w_ovf ? w_room : CNT_W'(w_push);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) r_mem[i] <= CB'(NARCH + i);
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= CNT_W'(FL_DEPTH);
      r_overflow <= 1'b0;
    end else begin
      // Excess candidates beyond the free room are silently dropped.
      for (int j = 0; j < NCAND; j++)
        if (32'(j) < 32'(w_acc)) r_mem[wrap(r_tail, 32'(j))] <= w_comp[j];
      r_head  <= wrap(r_head, 32'(w_pops));
      r_tail  <= wrap(r_tail, 32'(w_acc));
      r_count <= w_live + w_acc;
      if (w_ovf) r_overflow <= 1'b1;
    end
  end

  assign free_count = r_count;
  assign free_avail = (r_count >= CNT_W'(NW)) ? AVAIL_W'(NW) : AVAIL_W'(r_count);
  assign overflow   = r_overflow;
endmodule
